// File: rtl/zero_mem_arbiter.sv
// Round-robin arbiter sharing one memory port among NR_REQ requesters, one transaction in flight.
// Optional response watchdog enabled by defining ZERO_MEM_ARB_TIMEOUT_EN.
module zero_mem_arbiter #(
  parameter int NR_REQ  = 2,
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 256
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [NR_REQ-1:0]            req_valid,
  output logic [NR_REQ-1:0]            req_ready,
  input  logic [NR_REQ*ADDR_W-1:0]     req_addr,
  input  logic [NR_REQ-1:0]            req_wen,
  input  logic [NR_REQ*DATA_W-1:0]     req_wdata,
  input  logic [NR_REQ*DATA_W/8-1:0]   req_wmask,
  output logic [NR_REQ-1:0]            resp_valid,
  output logic [DATA_W-1:0]            resp_rdata,
  output logic                         resp_err,
  output logic                         mem_req_valid,
  input  logic                         mem_req_ready,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic                         mem_wen,
  output logic [DATA_W-1:0]            mem_wdata,
  output logic [DATA_W/8-1:0]          mem_wmask,
  input  logic                         mem_resp_valid,
  input  logic [DATA_W-1:0]            mem_rdata,
  output logic                         busy
);

  localparam int PTR_W  = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]      owner_q, owner_d;
  logic                  active_q, active_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic                  wen_q, wen_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [STRB_W-1:0]     wmask_q, wmask_d;

  logic                  grant_found_s;
  logic [PTR_W-1:0]      grant_idx_s;
  logic [PTR_W:0]        cand_s;
  logic [PTR_W-1:0]      next_ptr_s;
  logic                  timeout_s;

  // Circular scan for the first pending requester starting at rr_ptr.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    cand_s        = '0;
    for (int i = 0; i < NR_REQ; i++) begin
      cand_s = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
      if (cand_s >= (PTR_W+1)'(NR_REQ)) begin
        cand_s = cand_s - (PTR_W+1)'(NR_REQ);
      end else begin
        cand_s = cand_s;
      end
      if (!grant_found_s && req_valid[cand_s[PTR_W-1:0]]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = cand_s[PTR_W-1:0];
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  assign next_ptr_s = (owner_q == PTR_W'(NR_REQ - 1)) ? '0 : owner_q + PTR_W'(1);

`ifdef ZERO_MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

  // Watchdog counter: cleared while issuing, counts silent WAIT cycles.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == ISSUE) begin
      tmo_cnt_d = '0;
    end else if ((state_q == WAIT) && !mem_resp_valid) begin
      tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
    end else begin
      tmo_cnt_d = tmo_cnt_q;
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  // Fires on the WAIT cycle whose increment would reach TIMEOUT.
  assign timeout_s = (state_q == WAIT) && !mem_resp_valid &&
                     (tmo_cnt_q == CNT_W'(TIMEOUT - 1));
`else
  assign timeout_s = 1'b0;
`endif

  // Next-state and combinational handshake outputs.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    active_d   = 1'b1;
    addr_d     = addr_q;
    wen_d      = wen_q;
    wdata_d    = wdata_q;
    wmask_d    = wmask_q;
    req_ready  = '0;
    resp_valid = '0;
    resp_err   = 1'b0;
    resp_rdata = mem_rdata;
    case (state_q)
      IDLE: begin
        // active_q holds off grants until the first edge after reset release.
        if (active_q && grant_found_s) begin
          req_ready[grant_idx_s] = 1'b1;
          owner_d = grant_idx_s;
          addr_d  = req_addr[grant_idx_s*ADDR_W +: ADDR_W];
          wen_d   = req_wen[grant_idx_s];
          wdata_d = req_wdata[grant_idx_s*DATA_W +: DATA_W];
          wmask_d = req_wmask[grant_idx_s*STRB_W +: STRB_W];
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (mem_req_ready) begin
          state_d = WAIT;
        end else begin
          state_d = ISSUE;
        end
      end
      WAIT: begin
        resp_valid[owner_q] = mem_resp_valid | timeout_s;
        if (mem_resp_valid) begin
          rr_ptr_d = next_ptr_s;
          state_d  = IDLE;
        end else if (timeout_s) begin
          resp_err   = 1'b1;
          resp_rdata = '0;
          rr_ptr_d   = next_ptr_s;
          state_d    = IDLE;
        end else begin
          state_d = WAIT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, pointer and latched request registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      active_q <= 1'b0;
      addr_q   <= '0;
      wen_q    <= 1'b0;
      wdata_q  <= '0;
      wmask_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      active_q <= active_d;
      addr_q   <= addr_d;
      wen_q    <= wen_d;
      wdata_q  <= wdata_d;
      wmask_q  <= wmask_d;
    end
  end

  assign mem_req_valid = (state_q == ISSUE);
  assign mem_addr      = addr_q;
  assign mem_wen       = wen_q;
  assign mem_wdata     = wdata_q;
  assign mem_wmask     = wmask_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_zero_mem_arbiter.sv
// Scoreboard bench for zero_mem_arbiter: directed stimulus queues expected grants,
// issues and responses; a negedge monitor pops and compares them.
module tb_zero_mem_arbiter;

  logic         clock = 1'b0;
  logic         reset_n;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [127:0] req_addr;
  logic [1:0]   req_wen;
  logic [127:0] req_wdata;
  logic [15:0]  req_wmask;
  logic [1:0]   resp_valid;
  logic [63:0]  resp_rdata;
  logic         resp_err;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic [63:0]  mem_addr;
  logic         mem_wen;
  logic [63:0]  mem_wdata;
  logic [7:0]   mem_wmask;
  logic         mem_resp_valid;
  logic [63:0]  mem_rdata;
  logic         busy;

  logic [63:0]  a0, a1, wd0, wd1;
  logic [7:0]   wm0, wm1;

  assign req_addr  = {a1, a0};
  assign req_wdata = {wd1, wd0};
  assign req_wmask = {wm1, wm0};

  always #5 clock = ~clock;

  zero_mem_arbiter #(.NR_REQ(2), .ADDR_W(64), .DATA_W(64), .TIMEOUT(16)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wen(req_wen), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .busy(busy)
  );

  typedef struct { logic [63:0] addr; logic wen; logic [63:0] wdata; logic [7:0] wmask; } issue_t;
  typedef struct { logic [1:0] onehot; logic [63:0] rdata; logic err; } resp_t;

  int     grant_q[$];
  issue_t issue_q[$];
  resp_t  resp_q[$];
  int     n_checks = 0;
  int     n_errs   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic exp_txn(input int g, input logic [63:0] addr, input logic wen,
                         input logic [63:0] wdata, input logic [7:0] wmask,
                         input logic push_resp, input logic [63:0] rdata, input logic err);
    issue_t it;
    resp_t  rt;
    it = '{addr, wen, wdata, wmask};
    rt = '{((g == 0) ? 2'b01 : 2'b10), rdata, err};
    grant_q.push_back(g);
    issue_q.push_back(it);
    if (push_resp) resp_q.push_back(rt);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'h0);
    chk({tag, "_resp_valid"}, 64'(resp_valid), 64'h0);
    chk({tag, "_resp_err"}, 64'(resp_err), 64'h0);
    chk({tag, "_resp_rdata"}, resp_rdata, 64'h0);
    chk({tag, "_mem_req_valid"}, 64'(mem_req_valid), 64'h0);
    chk({tag, "_mem_addr"}, mem_addr, 64'h0);
    chk({tag, "_mem_wen"}, 64'(mem_wen), 64'h0);
    chk({tag, "_mem_wdata"}, mem_wdata, 64'h0);
    chk({tag, "_mem_wmask"}, 64'(mem_wmask), 64'h0);
    chk({tag, "_busy"}, 64'(busy), 64'h0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cyc();
    cyc();
    reset_n = 1'b1;
    cyc();
  endtask

  // Monitor: every DUT-presented grant, issue handshake and response is matched to the scoreboard.
  int          mon_g;
  issue_t      mon_i;
  resp_t       mon_r;
  logic [1:0]  mon_oh;
  always @(negedge clock) begin
    if (reset_n) begin
      if (req_ready != 2'b00) begin
        if (grant_q.size() == 0) begin
          n_checks++; n_errs++;
          $display("FAIL unexpected_grant: actual req_ready=%b required none", req_ready);
        end else begin
          mon_g  = grant_q.pop_front();
          mon_oh = 2'b01 << mon_g;
          chk("grant_onehot", 64'(req_ready), 64'(mon_oh));
        end
      end
      if (mem_req_valid && mem_req_ready) begin
        if (issue_q.size() == 0) begin
          n_checks++; n_errs++;
          $display("FAIL unexpected_issue: actual mem_addr=0x%0h required none", mem_addr);
        end else begin
          mon_i = issue_q.pop_front();
          chk("issue_addr", mem_addr, mon_i.addr);
          chk("issue_wen", 64'(mem_wen), 64'(mon_i.wen));
          chk("issue_wdata", mem_wdata, mon_i.wdata);
          chk("issue_wmask", 64'(mem_wmask), 64'(mon_i.wmask));
        end
      end
      if (resp_valid != 2'b00) begin
        if (resp_q.size() == 0) begin
          n_checks++; n_errs++;
          $display("FAIL unexpected_resp: actual resp_valid=%b required none", resp_valid);
        end else begin
          mon_r = resp_q.pop_front();
          chk("resp_valid", 64'(resp_valid), 64'(mon_r.onehot));
          chk("resp_rdata", resp_rdata, mon_r.rdata);
          chk("resp_err", 64'(resp_err), 64'(mon_r.err));
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    a0 = 64'h0; a1 = 64'h0; wd0 = 64'h0; wd1 = 64'h0; wm0 = 8'h0; wm1 = 8'h0;
    req_wen = 2'b00; mem_req_ready = 1'b0; mem_rdata = 64'h0;
    // Outputs must stay quiet in reset even with requests and responses present.
    req_valid = 2'b11; mem_resp_valid = 1'b1;
    cyc(); cyc();
    chk_all_zero("reset");
    req_valid = 2'b00; mem_resp_valid = 1'b0;
    reset_n = 1'b1;
    cyc();

    // 1: single read from requester 0.
    a0 = 64'h8000_0000; req_wen = 2'b00; req_valid = 2'b01; mem_req_ready = 1'b1;
    exp_txn(0, 64'h8000_0000, 1'b0, 64'h0, 8'h0, 1'b1, 64'h1234, 1'b0);
    #1 chk("t1_busy_t0", 64'(busy), 64'h0);
    cyc(); req_valid = 2'b00;
    #1 chk("t1_mem_req_valid_t1", 64'(mem_req_valid), 64'h1);
    chk("t1_mem_addr_t1", mem_addr, 64'h8000_0000);
    cyc();
    #1 chk("t1_busy_t2", 64'(busy), 64'h1);
    cyc(); mem_resp_valid = 1'b1; mem_rdata = 64'h1234;
    cyc(); mem_resp_valid = 1'b0; mem_rdata = 64'h0;
    #1 chk("t1_busy_t4", 64'(busy), 64'h0);

    // 2: both requesting from reset, immediate ready/response -> 0,1,0,1.
    do_reset();
    a0 = 64'h100; a1 = 64'h200; wd0 = 64'h11; wd1 = 64'h22; wm0 = 8'hFF; wm1 = 8'hF0;
    req_wen = 2'b00; mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_rdata = 64'hCAFE_F00D;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) exp_txn(0, 64'h100, 1'b0, 64'h11, 8'hFF, 1'b1, 64'hCAFE_F00D, 1'b0);
      else            exp_txn(1, 64'h200, 1'b0, 64'h22, 8'hF0, 1'b1, 64'hCAFE_F00D, 1'b0);
    end
    req_valid = 2'b11;
    repeat (11) cyc();
    req_valid = 2'b00;
    cyc(); mem_resp_valid = 1'b0; mem_rdata = 64'h0;
    #1 chk("t2_busy_end", 64'(busy), 64'h0);

    // 3: write from requester 1 with mem_req_ready held low for 5 cycles.
    a1 = 64'h10; wd1 = 64'hDEAD_BEEF; wm1 = 8'h0F; req_wen = 2'b10; req_valid = 2'b10;
    mem_req_ready = 1'b0;
    exp_txn(1, 64'h10, 1'b1, 64'hDEAD_BEEF, 8'h0F, 1'b1, 64'h55, 1'b0);
    cyc(); req_valid = 2'b00;
    for (int k = 1; k <= 5; k++) begin
      #1;
      chk("t3_mem_req_valid", 64'(mem_req_valid), 64'h1);
      chk("t3_mem_addr", mem_addr, 64'h10);
      chk("t3_mem_wen", 64'(mem_wen), 64'h1);
      chk("t3_mem_wdata", mem_wdata, 64'hDEAD_BEEF);
      chk("t3_mem_wmask", 64'(mem_wmask), 64'h0F);
      chk("t3_req_ready", 64'(req_ready), 64'h0);
      cyc();
    end
    mem_req_ready = 1'b1;
    #1 chk("t3_mem_req_valid_6th", 64'(mem_req_valid), 64'h1);
    cyc(); mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 64'h55;
    cyc(); mem_resp_valid = 1'b0; mem_rdata = 64'h0; req_wen = 2'b00;

    // 4: stray responses in IDLE and ISSUE are ignored.
    mem_resp_valid = 1'b1; mem_rdata = 64'h44;
    #1 chk("t4_idle_resp_valid", 64'(resp_valid), 64'h0);
    chk("t4_idle_busy", 64'(busy), 64'h0);
    cyc(); mem_resp_valid = 1'b0;
    a0 = 64'h40; wd0 = 64'h0; wm0 = 8'h0; req_valid = 2'b01;
    exp_txn(0, 64'h40, 1'b0, 64'h0, 8'h0, 1'b1, 64'h77, 1'b0);
    cyc(); req_valid = 2'b00; mem_resp_valid = 1'b1; mem_rdata = 64'h66;
    #1 chk("t4_issue_resp_valid", 64'(resp_valid), 64'h0);
    chk("t4_issue_mem_req_valid", 64'(mem_req_valid), 64'h1);
    cyc(); mem_resp_valid = 1'b0; mem_req_ready = 1'b1;
    cyc(); mem_req_ready = 1'b0;
    #1 chk("t4_wait_busy", 64'(busy), 64'h1);
    chk("t4_wait_resp_valid", 64'(resp_valid), 64'h0);
    cyc(); mem_resp_valid = 1'b1; mem_rdata = 64'h77;
    cyc(); mem_resp_valid = 1'b0; mem_rdata = 64'h0;

    // 5: reset in WAIT abandons the transaction; rr_ptr returns to 0.
    a0 = 64'h20; req_valid = 2'b01; mem_req_ready = 1'b1;
    exp_txn(0, 64'h20, 1'b0, 64'h0, 8'h0, 1'b0, 64'h0, 1'b0);
    cyc(); req_valid = 2'b00;
    cyc();
    #1 chk("t5_busy_before_reset", 64'(busy), 64'h1);
    reset_n = 1'b0; req_valid = 2'b10; a1 = 64'h30; wd1 = 64'h0; wm1 = 8'h0;
    #1 chk_all_zero("t5_reset");
    exp_txn(1, 64'h30, 1'b0, 64'h0, 8'h0, 1'b1, 64'h99, 1'b0);
    cyc(); reset_n = 1'b1;
    cyc();
    cyc(); req_valid = 2'b00;
    cyc(); mem_resp_valid = 1'b1; mem_rdata = 64'h99;
    cyc(); mem_resp_valid = 1'b0; mem_rdata = 64'h0;

`ifdef ZERO_MEM_ARB_TIMEOUT_EN
    // 6: no response -> timeout error on the 16th WAIT cycle, then rotate.
    a0 = 64'h500; req_valid = 2'b01; mem_req_ready = 1'b1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    exp_txn(0, 64'h500, 1'b0, 64'h0, 8'h0, 1'b1, 64'h0, 1'b1);
    cyc(); req_valid = 2'b00;
    cyc();
    repeat (14) cyc();
    #1 chk("t6_no_resp_15th", 64'(resp_valid), 64'h0);
    chk("t6_busy_15th", 64'(busy), 64'h1);
    cyc();
    #1 chk("t6_timeout_valid", 64'(resp_valid), 64'h1);
    chk("t6_timeout_err", 64'(resp_err), 64'h1);
    chk("t6_timeout_rdata", resp_rdata, 64'h0);
    cyc();
    a1 = 64'h600; req_valid = 2'b11;
    exp_txn(1, 64'h600, 1'b0, 64'h0, 8'h0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    #1 chk("t6_busy_after", 64'(busy), 64'h0);
    cyc(); req_valid = 2'b00;
    cyc(); mem_resp_valid = 1'b1;
    cyc(); mem_resp_valid = 1'b0; mem_rdata = 64'h0;
`endif

    cyc();
    chk("end_grant_q_empty", 64'(grant_q.size()), 64'h0);
    chk("end_issue_q_empty", 64'(issue_q.size()), 64'h0);
    chk("end_resp_q_empty", 64'(resp_q.size()), 64'h0);
    chk("end_busy", 64'(busy), 64'h0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
